linear_layer_srl_fifo_ctrl: RTL and testbench



---
 rtl/linear_layer_srl_fifo_ctrl.sv | 112 +++++++++++
 tb/tb_linear_layer_srl_fifo_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/linear_layer_srl_fifo_ctrl.sv
// linear_layer_srl_fifo_ctrl
//
// Handshaked FIFO built around a shift-register (SRL style) store. Every push shifts
// the whole store by one, so the newest entry always sits at index 0 and the oldest
// at index ptr. The FIFO only has to track the read pointer, not a write pointer.
// Used on each inter-process channel of the Linear_Layer dataflow region.
//
// Parameters:
//   DATA_WIDTH - payload width in bits
//   ADDR_WIDTH - storage address width, 2**ADDR_WIDTH >= DEPTH
//   DEPTH      - number of entries, >= 2
//
// Ports:
//   clk         in   single clock, rising edge
//   reset       in   synchronous, active-high
//   if_write_ce in   write-side clock enable
//   if_write    in   producer write request
//   if_din      in   write data
//   if_full_n   out  1 = space available (registered)
//   if_read_ce  in   read-side clock enable
//   if_read     in   consumer read request
//   if_dout     out  head-of-queue data, from registered ptr only
//   if_empty_n  out  1 = data available (registered)
//   count       out  occupancy 0..DEPTH (registered)

module linear_layer_srl_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned ADDR_WIDTH = 1,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int unsigned MemDepth = 1 << ADDR_WIDTH;

    // ptr value just before the DEPTH-th entry lands; a push from here fills the FIFO.
    localparam logic [ADDR_WIDTH:0] PtrLastFree = (ADDR_WIDTH + 1)'(DEPTH - 2);
    localparam logic [ADDR_WIDTH:0] PtrEmpty    = '1;
    localparam logic [ADDR_WIDTH:0] PtrOne      = (ADDR_WIDTH + 1)'(1);

    // Shift-register store. Not reset: contents are don't-care until pushed.
    logic [DATA_WIDTH-1:0] mem_q [MemDepth];

    logic [ADDR_WIDTH:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic                full_n_q, full_n_d;
    logic                empty_n_q, empty_n_d;
    logic                push, pop;

    assign push = if_write & if_write_ce & full_n_q;
    assign pop  = if_read & if_read_ce & empty_n_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[0] <= if_din;
            for (int i = 1; i < MemDepth; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    always_comb begin
        ptr_d     = ptr_q;
        full_n_d  = full_n_q;
        empty_n_d = empty_n_q;
        if (push && !pop) begin
            ptr_d     = ptr_q + PtrOne;
            empty_n_d = 1'b1;
            if (ptr_q == PtrLastFree) begin
                full_n_d = 1'b0;
            end
        end else if (pop && !push) begin
            ptr_d    = ptr_q - PtrOne;
            full_n_d = 1'b1;
            if (ptr_q == '0) begin
                empty_n_d = 1'b0;
            end
        end
        // push & pop: ptr holds, the shift alone advances the head.
        count_d = ptr_d + PtrOne;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q     <= PtrEmpty;
            count_q   <= '0;
            full_n_q  <= 1'b1;
            empty_n_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            count_q   <= count_d;
            full_n_q  <= full_n_d;
            empty_n_q <= empty_n_d;
        end
    end

    assign if_dout    = mem_q[ptr_q[ADDR_WIDTH-1:0]];
    assign if_full_n  = full_n_q;
    assign if_empty_n = empty_n_q;
    assign count      = count_q;

endmodule

// File: tb/tb_linear_layer_srl_fifo_ctrl.sv
// Directed bench for linear_layer_srl_fifo_ctrl: one DEPTH=2 and one DEPTH=4 instance.
module tb_linear_layer_srl_fifo_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // DEPTH=2 instance
    logic       a_rst, a_wce, a_wr, a_rce, a_rd;
    logic [7:0] a_din, a_dout;
    logic       a_full_n, a_empty_n;
    logic [1:0] a_count;

    // DEPTH=4 instance
    logic       b_rst, b_wce, b_wr, b_rce, b_rd;
    logic [7:0] b_din, b_dout;
    logic       b_full_n, b_empty_n;
    logic [2:0] b_count;

    linear_layer_srl_fifo_ctrl #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(1),
        .DEPTH     (2)
    ) u_d2 (
        .clk        (clk),
        .reset      (a_rst),
        .if_write_ce(a_wce),
        .if_write   (a_wr),
        .if_din     (a_din),
        .if_full_n  (a_full_n),
        .if_read_ce (a_rce),
        .if_read    (a_rd),
        .if_dout    (a_dout),
        .if_empty_n (a_empty_n),
        .count      (a_count)
    );

    linear_layer_srl_fifo_ctrl #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(2),
        .DEPTH     (4)
    ) u_d4 (
        .clk        (clk),
        .reset      (b_rst),
        .if_write_ce(b_wce),
        .if_write   (b_wr),
        .if_din     (b_din),
        .if_full_n  (b_full_n),
        .if_read_ce (b_rce),
        .if_read    (b_rd),
        .if_dout    (b_dout),
        .if_empty_n (b_empty_n),
        .count      (b_count)
    );

    // Advance one rising edge and settle; inputs are then driven and outputs sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_rst = 1'b1; b_rst = 1'b1;
        step(); step();
        a_rst = 1'b0; b_rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_chk++;
            if (a_full_n !== 1'b1) $display("FAIL reset_full_n cyc%0d: got %b want 1", i, a_full_n);
            else n_pass++;
            n_chk++;
            if (a_empty_n !== 1'b0) $display("FAIL reset_empty_n cyc%0d: got %b want 0", i, a_empty_n);
            else n_pass++;
            n_chk++;
            if (a_count !== 2'd0) $display("FAIL reset_count cyc%0d: got %0d want 0", i, a_count);
            else n_pass++;
            step();
        end
        n_chk++;
        if (b_count !== 3'd0 || b_empty_n !== 1'b0 || b_full_n !== 1'b1)
            $display("FAIL reset_d4: got count=%0d empty_n=%b full_n=%b want 0/0/1",
                     b_count, b_empty_n, b_full_n);
        else n_pass++;
    endtask

    task automatic test_fill_d2();
        a_wr = 1'b1; a_din = 8'hA1;
        step();
        n_chk++;
        if (a_empty_n !== 1'b1 || a_dout !== 8'hA1 || a_count !== 2'd1)
            $display("FAIL d2_push1: got empty_n=%b dout=%h count=%0d want 1/a1/1",
                     a_empty_n, a_dout, a_count);
        else n_pass++;
        a_din = 8'hB2;
        step();
        n_chk++;
        if (a_full_n !== 1'b0 || a_count !== 2'd2 || a_dout !== 8'hA1)
            $display("FAIL d2_push2: got full_n=%b count=%0d dout=%h want 0/2/a1",
                     a_full_n, a_count, a_dout);
        else n_pass++;
        a_din = 8'hC3;
        step();
        n_chk++;
        if (a_full_n !== 1'b0 || a_count !== 2'd2 || a_dout !== 8'hA1)
            $display("FAIL d2_write_full: got full_n=%b count=%0d dout=%h want 0/2/a1",
                     a_full_n, a_count, a_dout);
        else n_pass++;
        a_wr = 1'b0; a_rd = 1'b1;
        step();
        n_chk++;
        if (a_dout !== 8'hB2 || a_count !== 2'd1 || a_full_n !== 1'b1 || a_empty_n !== 1'b1)
            $display("FAIL d2_pop1: got dout=%h count=%0d full_n=%b empty_n=%b want b2/1/1/1",
                     a_dout, a_count, a_full_n, a_empty_n);
        else n_pass++;
        step();
        a_rd = 1'b0;
        n_chk++;
        if (a_empty_n !== 1'b0 || a_count !== 2'd0)
            $display("FAIL d2_pop2: got empty_n=%b count=%0d want 0/0", a_empty_n, a_count);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        b_wr = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            b_din = 8'(k);
            step();
        end
        n_chk++;
        if (b_count !== 3'd3 || b_dout !== 8'd1 || b_full_n !== 1'b1)
            $display("FAIL d4_fill3: got count=%0d dout=%0d full_n=%b want 3/1/1",
                     b_count, b_dout, b_full_n);
        else n_pass++;
        b_rd = 1'b1;
        b_din = 8'd4;
        step();
        n_chk++;
        if (b_dout !== 8'd2 || b_count !== 3'd3 || b_full_n !== 1'b1)
            $display("FAIL d4_pushpop: got dout=%0d count=%0d full_n=%b want 2/3/1",
                     b_dout, b_count, b_full_n);
        else n_pass++;
        for (int k = 5; k <= 20; k++) begin
            b_din = 8'(k);
            step();
            n_chk++;
            if (b_dout !== 8'(k - 2) || b_count !== 3'd3 || b_empty_n !== 1'b1)
                $display("FAIL d4_stream k=%0d: got dout=%0d count=%0d want %0d/3",
                         k, b_dout, b_count, k - 2);
            else n_pass++;
        end
        // Drain the 18,19,20 left behind.
        b_wr = 1'b0;
        step();
        n_chk++;
        if (b_dout !== 8'd19) $display("FAIL d4_drain1: got %0d want 19", b_dout);
        else n_pass++;
        step();
        n_chk++;
        if (b_dout !== 8'd20) $display("FAIL d4_drain2: got %0d want 20", b_dout);
        else n_pass++;
        step();
        b_rd = 1'b0;
        n_chk++;
        if (b_empty_n !== 1'b0 || b_count !== 3'd0)
            $display("FAIL d4_drain3: got empty_n=%b count=%0d want 0/0", b_empty_n, b_count);
        else n_pass++;
    endtask

    task automatic test_full_rw();
        b_wr = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            b_din = 8'(k);
            step();
        end
        n_chk++;
        if (b_full_n !== 1'b0 || b_count !== 3'd4 || b_dout !== 8'd1)
            $display("FAIL d4_full: got full_n=%b count=%0d dout=%0d want 0/4/1",
                     b_full_n, b_count, b_dout);
        else n_pass++;
        b_rd = 1'b1; b_din = 8'h99;
        step();
        b_wr = 1'b0;
        n_chk++;
        if (b_dout !== 8'd2 || b_count !== 3'd3 || b_full_n !== 1'b1)
            $display("FAIL d4_full_rw: got dout=%0d count=%0d full_n=%b want 2/3/1",
                     b_dout, b_count, b_full_n);
        else n_pass++;
        step();
        n_chk++;
        if (b_dout !== 8'd3) $display("FAIL d4_full_drain1: got %0d want 3", b_dout);
        else n_pass++;
        step();
        n_chk++;
        if (b_dout !== 8'd4) $display("FAIL d4_full_drain2: got %0d want 4", b_dout);
        else n_pass++;
        step();
        b_rd = 1'b0;
        n_chk++;
        if (b_empty_n !== 1'b0 || b_count !== 3'd0)
            $display("FAIL d4_full_drain3: got empty_n=%b count=%0d want 0/0", b_empty_n, b_count);
        else n_pass++;
    endtask

    task automatic test_ce_gating();
        b_wr = 1'b1; b_wce = 1'b0; b_din = 8'h11;
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++;
            if (b_count !== 3'd0 || b_empty_n !== 1'b0 || b_full_n !== 1'b1)
                $display("FAIL ce_write cyc%0d: got count=%0d empty_n=%b want 0/0", i,
                         b_count, b_empty_n);
            else n_pass++;
        end
        b_wr = 1'b0; b_wce = 1'b1; b_rd = 1'b1;
        step();
        n_chk++;
        if (b_count !== 3'd0 || b_empty_n !== 1'b0)
            $display("FAIL pop_empty: got count=%0d empty_n=%b want 0/0", b_count, b_empty_n);
        else n_pass++;
        b_wr = 1'b1; b_din = 8'h55;
        step();
        b_wr = 1'b0; b_rd = 1'b0;
        n_chk++;
        if (b_dout !== 8'h55 || b_count !== 3'd1 || b_empty_n !== 1'b1)
            $display("FAIL rw_empty: got dout=%h count=%0d empty_n=%b want 55/1/1",
                     b_dout, b_count, b_empty_n);
        else n_pass++;
        // Read enable low: a read request must not pop.
        b_rd = 1'b1; b_rce = 1'b0;
        step();
        b_rd = 1'b0; b_rce = 1'b1;
        n_chk++;
        if (b_count !== 3'd1 || b_dout !== 8'h55)
            $display("FAIL ce_read: got count=%0d dout=%h want 1/55", b_count, b_dout);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        b_wr = 1'b1; b_din = 8'hAA;
        step();
        b_din = 8'hBB;
        step();
        n_chk++;
        if (b_count !== 3'd3) $display("FAIL mid_pre: got count=%0d want 3", b_count);
        else n_pass++;
        b_rst = 1'b1; b_din = 8'hCC;
        step();
        b_rst = 1'b0; b_wr = 1'b0;
        n_chk++;
        if (b_count !== 3'd0 || b_empty_n !== 1'b0 || b_full_n !== 1'b1)
            $display("FAIL mid_reset: got count=%0d empty_n=%b full_n=%b want 0/0/1",
                     b_count, b_empty_n, b_full_n);
        else n_pass++;
        b_wr = 1'b1; b_din = 8'h7E;
        step();
        b_wr = 1'b0;
        n_chk++;
        if (b_dout !== 8'h7E || b_count !== 3'd1 || b_empty_n !== 1'b1)
            $display("FAIL mid_push: got dout=%h count=%0d empty_n=%b want 7e/1/1",
                     b_dout, b_count, b_empty_n);
        else n_pass++;
        b_rd = 1'b1;
        step();
        b_rd = 1'b0;
        n_chk++;
        if (b_empty_n !== 1'b0 || b_count !== 3'd0)
            $display("FAIL mid_pop: got empty_n=%b count=%0d want 0/0", b_empty_n, b_count);
        else n_pass++;
    endtask

    initial begin
        a_rst = 1'b1; a_wce = 1'b1; a_wr = 1'b0; a_rce = 1'b1; a_rd = 1'b0; a_din = '0;
        b_rst = 1'b1; b_wce = 1'b1; b_wr = 1'b0; b_rce = 1'b1; b_rd = 1'b0; b_din = '0;
        #1;
        test_reset();
        test_fill_d2();
        test_back_to_back();
        test_full_rw();
        test_ce_gating();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
